imem_port_arb: RTL and testbench
================================

Name: imem_port_arb

Overview:
- Arbitrates the single-port, 1024-word instruction memory between two requesters: the core fetch unit (read-only) and the program loader/debug port (read/write).
- Sits between the fetch stage and the instruction memory array.
- Converts byte addresses to word addresses and applies priority with anti-starvation.
- Supports a lock mode for uninterrupted program-load bursts, and returns read data tagged to the correct requester.

Parameters:
- ADDR_W, 10, word-address width of the memory (2^ADDR_W words).
- MAX_WAIT, 4, consecutive cycles the loader may be denied before it is forced ahead of fetch (1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- f_req  input  1  fetch read request
- f_addr  input  32  fetch byte address
- f_gnt  output  1  fetch request accepted this cycle
- f_rvalid  output  1  fetch read data valid
- f_rdata  output  32  fetch read data
- l_req  input  1  loader request
- l_we  input  1  loader write enable (qualified by l_req)
- l_lock  input  1  loader requests exclusive ownership
- l_addr  input  32  loader byte address
- l_wdata  input  32  loader write data
- l_gnt  output  1  loader request accepted this cycle
- l_rvalid  output  1  loader read data valid (reads only)
- l_rdata  output  32  loader read data
- locked  output  1  loader currently owns memory exclusively
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory word address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset (clk edge with rst=1) forces these values to 0: outputs, starve counter, owner tag, state=ARB. Any in-flight read is discarded, so no rvalid appears the cycle after reset.
- Grants are combinational from current inputs and state; at most one grant per cycle. mem_en = f_gnt | l_gnt.
- mem_addr = selected addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^ADDR_W words.
- mem_we = l_gnt & l_we. mem_wdata = l_wdata.
- Read latency is exactly 1 cycle. A registered owner tag (NONE/FETCH/LOAD) captured on a granted read steers mem_rdata into f_rdata or l_rdata the next cycle, asserting f_rvalid or l_rvalid for one cycle.
- A non-owner rdata output holds its last value. Writes produce no rvalid.
- State ARB:
  - f_req only -> fetch granted.
  - l_req only -> loader granted.
  - Both -> fetch granted, unless starve counter == MAX_WAIT, in which case loader granted.
  - Starve counter increments (saturating at MAX_WAIT) each cycle l_req is asserted and denied. It clears on l_gnt or when l_req=0.
  - l_req & l_lock & l_gnt -> LOCKED next cycle.
- State LOCKED:
  - f_gnt=0 always.
  - locked=1.
  - Loader granted every cycle l_req=1.
  - Exits to ARB the cycle after l_lock=0 is sampled; the exit cycle itself still denies fetch.
- Simultaneous l_req and l_lock rising while fetch wins the tie: lock not taken until the loader is actually granted.
- The requester holds req/addr until gnt; requests may be withdrawn without effect.

Optional Feature:
- Macro IMEM_ARB_ALIGN_CHK_EN.
- Defined: adds output misalign_err (1 bit), registered.
  - Pulses 1 for one cycle after any grant whose addr[1:0] != 0.
  - The access still proceeds with bits [1:0] dropped.
  - Reset value 0.
- Undefined: port and logic absent; misaligned addresses are silently truncated.

Test Plan:
- Reset: hold rst=1 with f_req=1 -> f_gnt=0, mem_en=0, f_rvalid=0. Release rst -> f_gnt=1 in the first cycle, f_rvalid=1 the next.
- Fetch read: mem preloaded word 0 = 32'hFFC4A303; f_req=1, f_addr=0 -> mem_addr=0 that cycle; next cycle f_rvalid=1, f_rdata=32'hFFC4A303, l_rvalid=0.
- Contention: f_req and l_req both held continuously, MAX_WAIT=4 -> fetch granted 4 cycles, loader granted on the 5th cycle, then the pattern repeats.
- Lock burst: l_req=l_lock=l_we=1, l_addr=0,4,8 with data A1,A2,A3 and f_req held -> locked=1, f_gnt=0 throughout. Drop l_lock -> fetch granted the second cycle after. Fetch read of word 2 returns A3.
- Wrap: l_addr=32'h00001004 write 32'h12345678 -> mem_addr=1. Fetch of address 4 reads 32'h12345678.
- Reset mid-read: grant fetch read, assert rst the next edge -> f_rvalid stays 0 and state returns to ARB. With IMEM_ARB_ALIGN_CHK_EN defined, f_addr=2 -> misalign_err=1 for one cycle.

Source files
------------

// File: rtl/imem_port_arb.sv
// Instruction-memory port arbiter: fetch (read-only) vs loader/debug (read/write), with
// anti-starvation, lock bursts and owner-tagged read return. Optional IMEM_ARB_ALIGN_CHK_EN adds misalign_err.
module imem_port_arb #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
`ifdef IMEM_ARB_ALIGN_CHK_EN
  output logic              misalign_err,
`endif
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_LOAD = 2'd2} owner_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state_r, state_s;
  owner_t      owner_r, owner_s;
  logic [3:0]  starve_r, starve_s;
  logic [31:0] f_hold_r, l_hold_r;
  logic [31:0] sel_addr_s;

  // Grant selection and lock state transitions; nothing is granted while in reset
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_s = state_r;
    if (rst) begin
      state_s = ARB;
    end else begin
      case (state_r)
        ARB: begin
          if (l_req && (!f_req || (starve_r == MAX_WAIT_C))) begin
            l_gnt = 1'b1;
          end else begin
            l_gnt = 1'b0;
          end
          f_gnt = f_req & ~l_gnt;
          if (l_req && l_lock && l_gnt) begin
            state_s = LOCKED;
          end else begin
            state_s = ARB;
          end
        end
        LOCKED: begin
          l_gnt = l_req;
          f_gnt = 1'b0;
          if (!l_lock) begin
            state_s = ARB;
          end else begin
            state_s = LOCKED;
          end
        end
        default: begin
          state_s = ARB;
        end
      endcase
    end
  end

  // Starve counter and read-owner tag for the next cycle
  always_comb begin
    starve_s = 4'd0;
    owner_s  = OWN_NONE;
    if (l_req && !l_gnt) begin
      if (starve_r == MAX_WAIT_C) begin
        starve_s = starve_r;
      end else begin
        starve_s = starve_r + 4'd1;
      end
    end else begin
      starve_s = 4'd0;
    end
    if (f_gnt) begin
      owner_s = OWN_FETCH;
    end else if (l_gnt && !l_we) begin
      owner_s = OWN_LOAD;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  // Memory-side strobes; byte address becomes word address, extra bits wrap away
  always_comb begin
    sel_addr_s = l_gnt ? l_addr : f_addr;
    mem_en     = f_gnt | l_gnt;
    mem_we     = l_gnt & l_we;
    mem_addr   = sel_addr_s[ADDR_W+1:2];
    mem_wdata  = l_wdata;
  end

  // Read return: memory data passes through to the owner, others hold their last value
  always_comb begin
    f_rvalid = (owner_r == OWN_FETCH);
    l_rvalid = (owner_r == OWN_LOAD);
    f_rdata  = f_rvalid ? mem_rdata : f_hold_r;
    l_rdata  = l_rvalid ? mem_rdata : l_hold_r;
    locked   = (state_r == LOCKED);
  end

  // State, starve counter, owner tag and rdata hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ARB;
      owner_r  <= OWN_NONE;
      starve_r <= 4'd0;
      f_hold_r <= 32'd0;
      l_hold_r <= 32'd0;
    end else begin
      state_r  <= state_s;
      owner_r  <= owner_s;
      starve_r <= starve_s;
      f_hold_r <= f_rdata;
      l_hold_r <= l_rdata;
    end
  end

`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic misalign_r;

  // One-cycle pulse after any grant whose byte offset is non-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= mem_en & (sel_addr_s[1:0] != 2'b00);
    end
  end

  assign misalign_err = misalign_r;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, f_addr[31:ADDR_W+2], l_addr[31:ADDR_W+2], sel_addr_s[1:0],
                              sel_addr_s[31:ADDR_W+2]};

endmodule

// File: tb/tb_imem_port_arb.sv
// Directed self-checking bench for imem_port_arb with a behavioural 1-cycle-latency memory.
module tb_imem_port_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_we, l_lock;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid, locked, mem_en, mem_we;
  logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic        misalign_err;
`endif

  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_port_arb #(.ADDR_W(10), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef IMEM_ARB_ALIGN_CHK_EN
    .misalign_err(misalign_err),
`endif
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory with a preload port for the bench
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_l, prev_f, prev_l;
    rst = 1'b1; f_req = 1'b1; f_addr = 32'd0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = 32'd0; l_wdata = 32'd0;
    pre_en = 1'b1; pre_addr = 10'd0; pre_data = 32'hFFC4A303;
    cyc();
    pre_addr = 10'd1; pre_data = 32'h0BADF00D;
    cyc();
    pre_addr = 10'd2; pre_data = 32'hCAFE0002;
    cyc();
    pre_en = 1'b0;
    #1;
    chk("rst_f_gnt",    32'(f_gnt),    32'd0);
    chk("rst_mem_en",   32'(mem_en),   32'd0);
    chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_f_rdata",  f_rdata,       32'd0);
`ifdef IMEM_ARB_ALIGN_CHK_EN
    chk("rst_misalign", 32'(misalign_err), 32'd0);
`endif

    // first fetch right after reset release
    rst = 1'b0;
    #1;
    chk("fetch_gnt",      32'(f_gnt),    32'd1);
    chk("fetch_l_gnt",    32'(l_gnt),    32'd0);
    chk("fetch_mem_en",   32'(mem_en),   32'd1);
    chk("fetch_mem_addr", 32'(mem_addr), 32'd0);
    cyc();
    f_req = 1'b0;
    #1;
    chk("fetch_rvalid",   32'(f_rvalid), 32'd1);
    chk("fetch_rdata",    f_rdata,       32'hFFC4A303);
    chk("fetch_l_rvalid", 32'(l_rvalid), 32'd0);
    cyc();
    #1;
    chk("fetch_rvalid_drop", 32'(f_rvalid), 32'd0);
    chk("fetch_rdata_hold",  f_rdata,       32'hFFC4A303);

    // contention: four fetch grants then one loader grant, repeating
    f_req = 1'b1; f_addr = 32'd4; l_req = 1'b1; l_we = 1'b0; l_addr = 32'd8;
    prev_f = 1'b0; prev_l = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_l = ((i % 5) == 4);
      chk("cont_l_gnt",    32'(l_gnt),    32'(exp_l));
      chk("cont_f_gnt",    32'(f_gnt),    32'(!exp_l));
      chk("cont_f_rvalid", 32'(f_rvalid), 32'(prev_f));
      chk("cont_l_rvalid", 32'(l_rvalid), 32'(prev_l));
      if (prev_f) chk("cont_f_rdata", f_rdata, 32'h0BADF00D);
      if (prev_l) chk("cont_l_rdata", l_rdata, 32'hCAFE0002);
      prev_f = !exp_l;
      prev_l = exp_l;
      cyc();
    end
    f_req = 1'b0; l_req = 1'b0;
    cyc();

    // lock burst: lock only taken once the loader actually wins
    f_req = 1'b1; f_addr = 32'd0;
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1; l_addr = 32'd0; l_wdata = 32'h000000A1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lock_wait_f_gnt",  32'(f_gnt),  32'd1);
      chk("lock_wait_locked", 32'(locked), 32'd0);
      cyc();
    end
    #1;
    chk("lock_first_l_gnt", 32'(l_gnt),    32'd1);
    chk("lock_first_we",    32'(mem_we),   32'd1);
    chk("lock_first_addr",  32'(mem_addr), 32'd0);
    cyc();
    l_addr = 32'd4; l_wdata = 32'h000000A2;
    #1;
    chk("lock2_locked", 32'(locked),   32'd1);
    chk("lock2_f_gnt",  32'(f_gnt),    32'd0);
    chk("lock2_l_gnt",  32'(l_gnt),    32'd1);
    chk("lock2_addr",   32'(mem_addr), 32'd1);
    cyc();
    l_addr = 32'd8; l_wdata = 32'h000000A3;
    #1;
    chk("lock3_f_gnt", 32'(f_gnt),    32'd0);
    chk("lock3_addr",  32'(mem_addr), 32'd2);
    cyc();
    l_lock = 1'b0; l_req = 1'b0; l_we = 1'b0; f_addr = 32'd8;
    #1;
    chk("unlock_exit_locked", 32'(locked), 32'd1);
    chk("unlock_exit_f_gnt",  32'(f_gnt),  32'd0);
    chk("unlock_exit_mem_en", 32'(mem_en), 32'd0);
    cyc();
    #1;
    chk("unlock_locked", 32'(locked),   32'd0);
    chk("unlock_f_gnt",  32'(f_gnt),    32'd1);
    chk("unlock_addr",   32'(mem_addr), 32'd2);
    cyc();
    f_req = 1'b0;
    #1;
    chk("burst_read_rvalid", 32'(f_rvalid), 32'd1);
    chk("burst_read_rdata",  f_rdata,       32'h000000A3);
    cyc();

    // address wrap: upper byte-address bits are dropped
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h00001004; l_wdata = 32'h12345678;
    #1;
    chk("wrap_l_gnt", 32'(l_gnt),    32'd1);
    chk("wrap_we",    32'(mem_we),   32'd1);
    chk("wrap_addr",  32'(mem_addr), 32'd1);
    chk("wrap_wdata", mem_wdata,     32'h12345678);
    cyc();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'd4;
    #1;
    chk("write_no_rvalid", 32'(l_rvalid), 32'd0);
    chk("wrap_rd_addr",    32'(mem_addr), 32'd1);
    cyc();
    f_req = 1'b0;
    #1;
    chk("wrap_rd_rdata", f_rdata, 32'h12345678);

    // loader read routed only to the loader side
    l_req = 1'b1; l_addr = 32'd8;
    #1;
    chk("lrd_l_gnt", 32'(l_gnt), 32'd1);
    cyc();
    l_req = 1'b0;
    #1;
    chk("lrd_l_rvalid", 32'(l_rvalid), 32'd1);
    chk("lrd_l_rdata",  l_rdata,       32'h000000A3);
    chk("lrd_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("lrd_f_hold",   f_rdata,       32'h12345678);
    cyc();

    // reset while locked with a loader read in flight
    l_req = 1'b1; l_lock = 1'b1; l_addr = 32'd8;
    #1;
    chk("rmid_lock_gnt", 32'(l_gnt), 32'd1);
    cyc();
    #1;
    chk("rmid_locked", 32'(locked), 32'd1);
    cyc();
    l_req = 1'b0; l_lock = 1'b0; rst = 1'b1;
    #1;
    chk("rmid_rst_l_gnt", 32'(l_gnt), 32'd0);
    cyc();
    rst = 1'b0; f_req = 1'b1; f_addr = 32'd0; l_req = 1'b1; l_lock = 1'b1;
    #1;
    chk("rmid_locked_clr", 32'(locked),   32'd0);
    chk("rmid_l_rvalid",   32'(l_rvalid), 32'd0);
    chk("rmid_l_rdata",    l_rdata,       32'd0);
    chk("rmid_f_gnt",      32'(f_gnt),    32'd1);
    chk("rmid_l_gnt",      32'(l_gnt),    32'd0);
    cyc();
    #1;
    chk("tie_no_lock", 32'(locked), 32'd0);
    f_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
    cyc();

`ifdef IMEM_ARB_ALIGN_CHK_EN
    f_req = 1'b1; f_addr = 32'd2;
    cyc();
    f_req = 1'b0;
    #1;
    chk("misalign_pulse", 32'(misalign_err), 32'd1);
    cyc();
    #1;
    chk("misalign_clear", 32'(misalign_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
